fft_stage_sequencer: RTL

- Schedules radix-2 decimation-in-time butterflies for the in-place FFT datapath.
- Walks every stage and butterfly and issues memory addresses plus a twiddle index to the butterfly pipeline over a valid/ready handshake.
- Limits in-flight butterflies and drains write-backs between stages, so stage s+1 never reads data that stage s has not yet written.
- Sits between the FFT control unit (start/abort/done) and the butterfly engine/buffer memory.

---
 rtl/fft_stage_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT butterfly scheduler for the in-place FFT datapath.
// Issues per-stage address pairs and twiddles, drains write-backs between stages.
module fft_stage_sequencer #(
    parameter int FFT_MAX_LENGTH_LOG2 = 12,
    parameter int MAX_OUTSTANDING     = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic [3:0]                       length_log2_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o,
    output logic                             bf_valid_o,
    input  logic                             bf_ready_i,
    output logic [FFT_MAX_LENGTH_LOG2-1:0]   bf_addr_a_o,
    output logic [FFT_MAX_LENGTH_LOG2-1:0]   bf_addr_b_o,
    output logic [FFT_MAX_LENGTH_LOG2-2:0]   bf_twiddle_o,
    output logic [3:0]                       bf_stage_o,
    output logic                             bf_last_o,
    input  logic                             wb_done_i
);

    localparam int         AW      = FFT_MAX_LENGTH_LOG2;
    localparam int         KW      = AW - 1;
    localparam logic [3:0] MAX_LEN = 4'(AW);
    localparam logic [3:0] TW_SH   = 4'(AW - 1);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t        state_q;
    logic [3:0]    len_q;
    logic [3:0]    stage_q;
    logic [3:0]    outst_q;
    logic [KW-1:0] k_q;
    logic          done_q;
    logic          error_q;

    logic [AW-1:0] half;
    logic [AW-1:0] k_ext;
    logic [AW-1:0] pos;
    logic [AW-1:0] group;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [KW-1:0] twiddle;
    logic [KW-1:0] k_last;
    logic          in_issue;
    logic          can_issue;
    logic          accept;
    logic          wb_dec;
    logic          len_ok;
    logic          k_is_last;
    logic          stage_last;

    // Butterfly geometry from the registered stage/butterfly counters.
    always_comb begin
        half    = AW'(1) << stage_q;
        k_ext   = AW'(k_q);
        pos     = k_ext & (half - AW'(1));
        group   = k_ext >> stage_q;
        addr_a  = ((group << stage_q) << 1) | pos;
        addr_b  = addr_a + half;
        twiddle = KW'(pos << (TW_SH - stage_q));
        k_last  = KW'((AW'(1) << (len_q - 4'd1)) - AW'(1));
    end

    // Handshake and bookkeeping conditions.
    always_comb begin
        in_issue   = (state_q == ISSUE);
        can_issue  = in_issue && (outst_q < MAX_OUT);
        accept     = can_issue && bf_ready_i;
        wb_dec     = wb_done_i && (outst_q != 4'd0);
        len_ok     = (length_log2_i != 4'd0) &&
                     (length_log2_i <= MAX_LEN);
        k_is_last  = (k_q == k_last);
        stage_last = (stage_q == (len_q - 4'd1));
    end

    // Outputs: request fields are zeroed outside ISSUE.
    always_comb begin
        busy_o       = (state_q != IDLE);
        done_o       = done_q;
        error_o      = error_q;
        bf_valid_o   = can_issue;
        bf_addr_a_o  = in_issue ? addr_a : '0;
        bf_addr_b_o  = in_issue ? addr_b : '0;
        bf_twiddle_o = in_issue ? twiddle : '0;
        bf_stage_o   = stage_q;
        bf_last_o    = in_issue && stage_last && k_is_last;
    end

    // Sequencer FSM with outstanding-count tracking; abort overrides all.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            len_q   <= 4'd0;
            stage_q <= 4'd0;
            k_q     <= '0;
            outst_q <= 4'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                stage_q <= 4'd0;
                k_q     <= '0;
                outst_q <= 4'd0;
            end else begin
                unique case ({accept, wb_dec})
                    2'b10:   outst_q <= outst_q + 4'd1;
                    2'b01:   outst_q <= outst_q - 4'd1;
                    default: outst_q <= outst_q;
                endcase
                unique case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (len_ok) begin
                                len_q   <= length_log2_i;
                                stage_q <= 4'd0;
                                k_q     <= '0;
                                state_q <= ISSUE;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (accept) begin
                            if (k_is_last) begin
                                state_q <= DRAIN;
                            end else begin
                                k_q <= k_q + KW'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (outst_q == 4'd0) begin
                            if (stage_last) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                stage_q <= stage_q + 4'd1;
                                k_q     <= '0;
                                state_q <= ISSUE;
                            end
                        end
                    end
                    DONE: begin
                        stage_q <= 4'd0;
                        k_q     <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
